// File: rtl/data_memory_bh.sv
// Byte-addressable little-endian data memory for the MEM stage.
// It supports byte, half and word accesses, fault detection, and a ready/fault handshake with wait states.
module data_memory_bh #(
  parameter int MEM_BYTES   = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        fault
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    dout_q, dout_d;
  logic [1:0]     size_q, size_d;
  logic           sext_q, sext_d;
  logic           wr_q, wr_d;
  logic           fault_q, fault_d;
  logic [7:0]     mem_q [MEM_BYTES];

  logic [AW-1:0]  acc_idx;
  logic [AW-1:0]  idx_k [4];
  logic [31:0]    acc_wdata;
  logic [1:0]     acc_size;
  logic           acc_sext;
  logic           acc_wr;
  logic           acc_fault;
  logic [31:0]    raw;
  logic [3:0]     we;

  // The range test uses a 33-bit sum so that addresses near 2^32 cannot wrap back into range.
  function automatic logic req_fault(input logic rd, input logic wr,
                                     input logic [1:0] sz, input logic [31:0] a);
    logic [32:0] last;
    case (sz)
      2'b00:   last = {1'b0, a};
      2'b01:   last = {1'b0, a} + 33'd1;
      default: last = {1'b0, a} + 33'd3;
    endcase
    return (rd & wr) | (sz == 2'b11) | ((sz == 2'b01) & a[0]) |
           ((sz == 2'b10) & (a[1:0] != 2'b00)) | (last >= 33'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] r, input logic [1:0] sz,
                                              input logic se);
    case (sz)
      2'b00:   return {{24{se & r[7]}}, r[7:0]};
      2'b01:   return {{16{se & r[15]}}, r[15:0]};
      default: return r;
    endcase
  endfunction

  // When WAIT_STATES is 0, the access completes on the acceptance edge, so IDLE uses the live inputs.
  always_comb begin
    if (state_q == IDLE) begin
      acc_idx   = addr[AW-1:0];
      acc_wdata = data_in;
      acc_size  = size;
      acc_sext  = sign_ext;
      acc_wr    = MemWrite;
      acc_fault = req_fault(MemRead, MemWrite, size, addr);
    end else begin
      acc_idx   = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_sext  = sext_q;
      acc_wr    = wr_q;
      acc_fault = fault_q;
    end
    for (int k = 0; k < 4; k++) idx_k[k] = acc_idx + AW'(k);
    raw = {mem_q[idx_k[3]], mem_q[idx_k[2]], mem_q[idx_k[1]], mem_q[idx_k[0]]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    dout_d  = '0;
    we      = '0;
    case (state_q)
      IDLE: begin
        if (MemRead | MemWrite) begin
          addr_d  = addr[AW-1:0];
          wdata_d = data_in;
          size_d  = size;
          sext_d  = sign_ext;
          wr_d    = MemWrite;
          fault_d = acc_fault;
          if (WAIT_STATES > 0) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Stores commit and loads are captured on the edge that enters RESP.
    if ((state_d == RESP) && (state_q != RESP) && !acc_fault) begin
      if (acc_wr) begin
        case (acc_size)
          2'b00:   we = 4'b0001;
          2'b01:   we = 4'b0011;
          default: we = 4'b1111;
        endcase
      end else begin
        dout_d = load_extend(raw, acc_size, acc_sext);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    sext_q  <= sext_d;
    wr_q    <= wr_d;
  end

  // The array is not cleared by reset, but reset still blocks a commit that would land on the same edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) mem_q[idx_k[k]] <= acc_wdata[8*k +: 8];
      end
    end
  end

  assign ready    = (state_q == RESP);
  assign fault    = ready & fault_q;
  assign data_out = dout_q;

endmodule
